// File: rtl/handshake_constant_burst.sv
// handshake_constant_burst
// Each control token accepted on ctrl_* produces a burst of REPEAT output
// tokens carrying the constant VALUE. Output channel is fully registered;
// ctrl_ready only looks at outs_ready on the final beat of a burst so that
// a new burst can be chained onto the last beat without a bubble.
//
// Optional feature macro: HANDSHAKE_CONSTANT_BURST_LAST_EN
//   defined   -> extra registered output outs_last, high on the final beat
//   undefined -> port and logic absent
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no burst active, outs_valid=0, outs=0, ready for a token
// EMIT  | burst active, r_cnt = beats remaining including current

module handshake_constant_burst #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [63:0] VALUE      = 64'd0,
    parameter int          REPEAT     = 1,
    parameter int          CNT_WIDTH  = $clog2(REPEAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
    ,
    output logic                  outs_last
`endif
);

    generate
        if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
            $error("handshake_constant_burst: REPEAT must be within 1..65535");
        end
    endgenerate

    // VALUE is truncated or zero-extended to the output width here
    localparam logic [DATA_WIDTH-1:0] C_VALUE  = DATA_WIDTH'(VALUE);
    localparam logic [CNT_WIDTH-1:0]  C_REPEAT = CNT_WIDTH'(REPEAT);
    localparam logic [CNT_WIDTH-1:0]  C_ONE    = CNT_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_outs;

    state_t                  w_state_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   w_outs_nxt;

    logic                    w_busy;
    logic                    w_cnt_last;
    logic                    w_out_fire;
    logic                    w_ctrl_ready;
    logic                    w_ctrl_fire;

    assign w_busy       = (r_state == S_EMIT);
    assign w_cnt_last   = (r_cnt == C_ONE);
    assign w_out_fire   = w_busy & outs_ready;
    // outs_ready reaches ctrl_ready only on the final beat
    assign w_ctrl_ready = ~w_busy | (outs_ready & w_cnt_last);
    assign w_ctrl_fire  = ctrl_valid & w_ctrl_ready;

    assign ctrl_ready = w_ctrl_ready;
    assign outs_valid = w_busy;
    assign outs       = r_outs;

    // Next-state logic: start, step, reload or finish a burst
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_outs_nxt  = r_outs;
        case (r_state)
            S_IDLE: begin
                if (w_ctrl_fire) begin
                    w_state_nxt = S_EMIT;
                    w_cnt_nxt   = C_REPEAT;
                    w_outs_nxt  = C_VALUE;
                end
            end
            S_EMIT: begin
                if (w_out_fire) begin
                    if (!w_cnt_last) begin
                        w_cnt_nxt = r_cnt - C_ONE;
                    end else if (w_ctrl_fire) begin
                        w_cnt_nxt = C_REPEAT;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_outs_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_outs_nxt  = '0;
            end
        endcase
    end

    // State registers; reset discards any burst in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_outs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_outs  <= w_outs_nxt;
        end
    end

`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
    logic r_last;
    logic w_last_nxt;

    // Final-beat marker follows the same next-state as the burst counter
    always_comb begin
        w_last_nxt = (w_state_nxt == S_EMIT) && (w_cnt_nxt == C_ONE);
    end

    // Registered last flag so it is stable alongside outs during stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    assign outs_last = r_last;
`endif

endmodule

// File: tb/tb_handshake_constant_burst.sv
// Bench for handshake_constant_burst: five instances with different REPEAT
// values run side by side. A reference model of the burst behaviour checks
// every output each cycle, and a per-lane scoreboard queue receives REPEAT
// expected tokens per accepted control token and pops one per output fire.

module tb_handshake_constant_burst;

    localparam int NL = 5;
    localparam int DW = 27;
    localparam int          REP_T [NL] = '{1, 3, 2, 5, 4};
    localparam logic [63:0] VAL_T [NL] = '{64'h759B1D8, 64'h1234567, 64'hF5A5A5A5,
                                           64'h0ABCDEF, 64'h3C3C3C3};
    localparam logic [DW-1:0] EXP_T [NL] = '{27'h759B1D8, 27'h1234567, 27'h5A5A5A5,
                                            27'h0ABCDEF, 27'h3C3C3C3};

    logic          clk = 1'b0;
    logic          rst;
    logic          cv    [NL];
    logic          cr    [NL];
    logic          ov    [NL];
    logic          ordy  [NL];
    logic [DW-1:0] outs_a[NL];
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
    logic          olast [NL];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        handshake_constant_burst #(
            .DATA_WIDTH(DW),
            .VALUE     (VAL_T[g]),
            .REPEAT    (REP_T[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ctrl_valid(cv[g]),
            .ctrl_ready(cr[g]),
            .outs      (outs_a[g]),
            .outs_valid(ov[g]),
            .outs_ready(ordy[g])
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
            ,
            .outs_last (olast[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model state
    logic          m_busy [NL] = '{default: 1'b0};
    int            m_cnt  [NL] = '{default: 0};
    logic          armed = 1'b0;
    logic [DW-1:0] sb [NL][$];
    int            fire_cnt [NL] = '{default: 0};
    int            ctrl_cnt [NL] = '{default: 0};
    int            beat4 = 0;
    int            last_q [$];

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst) begin
                m_busy[l] <= 1'b0;
                m_cnt[l]  <= 0;
            end else if (!m_busy[l]) begin
                if (cv[l]) begin
                    m_busy[l] <= 1'b1;
                    m_cnt[l]  <= REP_T[l];
                end
            end else if (ordy[l]) begin
                if (m_cnt[l] > 1) begin
                    m_cnt[l] <= m_cnt[l] - 1;
                end else if (cv[l]) begin
                    m_cnt[l] <= REP_T[l];
                end else begin
                    m_busy[l] <= 1'b0;
                    m_cnt[l]  <= 0;
                end
            end
        end
        if (!rst) armed <= 1'b1;
    end

    always @(negedge clk) begin
        logic exp_rdy;
        for (int l = 0; l < NL; l++) begin
            exp_rdy = !m_busy[l] || (ordy[l] && m_cnt[l] == 1);
            if (armed) begin
                chk($sformatf("L%0d ctrl_ready", l), cr[l], exp_rdy);
                chk($sformatf("L%0d outs_valid", l), ov[l], m_busy[l]);
                chk($sformatf("L%0d outs", l), outs_a[l], m_busy[l] ? EXP_T[l] : '0);
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
                chk($sformatf("L%0d outs_last", l), olast[l], m_busy[l] && m_cnt[l] == 1);
`endif
            end
            if (!rst) begin
                sb[l].delete();
            end else if (armed) begin
                if (ov[l] && ordy[l]) begin
                    fire_cnt[l]++;
                    if (sb[l].size() == 0)
                        chk($sformatf("L%0d sb_underflow", l), 64'(sb[l].size()), 64'd1);
                    else
                        chk($sformatf("L%0d sb_token", l), outs_a[l], sb[l].pop_front());
                    if (l == 4) begin
                        beat4++;
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
                        if (olast[l]) last_q.push_back(beat4);
`endif
                    end
                end
                if (cv[l] && cr[l]) ctrl_cnt[l]++;
                if (cv[l] && exp_rdy)
                    for (int k = 0; k < REP_T[l]; k++) sb[l].push_back(EXP_T[l]);
            end
        end
    end

    initial begin
        rst  = 1'b0;
        cv   = '{default: 1'b0};
        ordy = '{default: 1'b0};
        repeat (3) step();
        rst = 1'b1;

        // reset state, REPEAT=1 lane
        @(negedge clk);
        chk("rst outs", outs_a[0], 0);
        chk("rst outs_valid", ov[0], 0);
        chk("rst ctrl_ready", cr[0], 1);

        // back-to-back REPEAT=1
        step(); cv[0] = 1; ordy[0] = 1;
        @(negedge clk);
        chk("t1 latency", ov[0], 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) cv[0] = 0;
            @(negedge clk);
            chk("t1 stream valid", ov[0], 1);
            chk("t1 stream outs", outs_a[0], 27'h759B1D8);
        end
        step();
        @(negedge clk);
        chk("t1 drained", ov[0], 0);
        repeat (2) step();
        chk("t1 out fires", fire_cnt[0], 4);
        chk("t1 ctrl fires", ctrl_cnt[0], 4);

        // burst of 3 with a stall on the second output cycle
        step(); cv[1] = 1; ordy[1] = 1;
        @(negedge clk); chk("t2 ready idle", cr[1], 1);
        step(); cv[1] = 0;
        @(negedge clk); chk("t2 ready b1", cr[1], 0);
        step(); ordy[1] = 0;
        @(negedge clk); chk("t2 ready stall", cr[1], 0);
        chk("t2 outs stall", outs_a[1], 27'h1234567);
        chk("t2 valid stall", ov[1], 1);
        step(); ordy[1] = 1;
        @(negedge clk); chk("t2 ready b2", cr[1], 0);
        chk("t2 outs after stall", outs_a[1], 27'h1234567);
        step();
        @(negedge clk); chk("t2 ready b3", cr[1], 1);
        step();
        @(negedge clk); chk("t2 idle", ov[1], 0);
        step(); ordy[1] = 0;
        chk("t2 out fires", fire_cnt[1], 3);

        // seamless reload, REPEAT=2
        step(); cv[2] = 1; ordy[2] = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 8) cv[2] = 0;
            @(negedge clk);
            chk("t3 no bubble", ov[2], 1);
            chk("t3 ready phase", cr[2], (i % 2) == 0);
        end
        step();
        @(negedge clk); chk("t3 drained", ov[2], 0);
        step();
        chk("t3 ctrl fires", ctrl_cnt[2], 4);
        chk("t3 out fires", fire_cnt[2], 8);

        // reset mid-burst, REPEAT=5
        step(); cv[3] = 1; ordy[3] = 1;
        step(); cv[3] = 0;
        step();
        step(); rst = 0;
        step(); rst = 1;
        @(negedge clk);
        chk("t4 valid after rst", ov[3], 0);
        chk("t4 outs after rst", outs_a[3], 0);
        chk("t4 ready after rst", cr[3], 1);
        chk("t4 beats before rst", fire_cnt[3], 2);
        cv[3] = 1;
        step(); cv[3] = 0;
        repeat (6) step();
        chk("t4 total beats", fire_cnt[3], 7);

        // two bursts of 4, stall on beat 4, second token held upstream
        step(); cv[4] = 1; ordy[4] = 1;
        repeat (3) step();
        step(); ordy[4] = 0;
        @(negedge clk); chk("t5 ready stall", cr[4], 0);
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
        chk("t5 last stall a", olast[4], 1);
`endif
        step();
        @(negedge clk);
        chk("t5 outs stall", outs_a[4], 27'h3C3C3C3);
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
        chk("t5 last stall b", olast[4], 1);
`endif
        step(); ordy[4] = 1;
        @(negedge clk); chk("t5 ready last", cr[4], 1);
        step(); cv[4] = 0;
        repeat (5) step();
        chk("t5 out fires", fire_cnt[4], 8);
        chk("t5 ctrl fires", ctrl_cnt[4], 2);
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
        chk("t5 last count", last_q.size(), 2);
        if (last_q.size() == 2) begin
            chk("t5 last beat a", last_q[0], 4);
            chk("t5 last beat b", last_q[1], 8);
        end
`endif

        for (int l = 0; l < NL; l++)
            chk($sformatf("L%0d sb empty", l), sb[l].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_constant_burst.md
Name: handshake_constant_burst

Overview:
- Parametrised successor to the dataflow constant source.
- Each token accepted on the control channel produces a burst of REPEAT output tokens, each carrying the compile-time constant VALUE.
- The output is registered, so the channel is timing-decoupled: one cycle of latency, and a combinational outs_ready to ctrl_ready path exists only on the final beat.
- Used where a loop body consumes the same constant several times per trigger token.

Parameters:
- DATA_WIDTH, 32, width of outs.
- VALUE, 0, constant emitted; truncated or zero-extended to DATA_WIDTH.
- REPEAT, 1, output tokens per control token; legal range 1..65535. Elaboration error if outside range.
- CNT_WIDTH, $clog2(REPEAT+1), derived width of the beat counter; not to be overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- ctrl_valid  input  1  control token present.
- ctrl_ready  output  1  block accepts control token this cycle.
- outs  output  DATA_WIDTH  constant data, registered.
- outs_valid  output  1  output token present, registered.
- outs_ready  input  1  downstream accepts output token.

Behaviour:
- Handshake events:
  - ctrl_fire = ctrl_valid & ctrl_ready.
  - out_fire = outs_valid & outs_ready.
- State registers: busy (1 bit), cnt (CNT_WIDTH, remaining beats including the current one), outs register.
- States:
  - IDLE (busy=0).
  - EMIT (busy=1).
- outs_valid = busy.
- ctrl_ready = !busy | (outs_ready & cnt==1). The combinational path exists only on the last beat, giving full throughput when REPEAT=1.
- Transitions:
  - IDLE, ctrl_fire: go to EMIT, cnt<=REPEAT, outs<=VALUE. outs_valid rises the next cycle (latency 1).
  - EMIT, out_fire with cnt>1: cnt<=cnt-1; stay in EMIT.
  - EMIT, out_fire with cnt==1 and no ctrl_fire: go to IDLE, cnt<=0, outs<=0.
  - EMIT, out_fire with cnt==1 and ctrl_fire in the same cycle: stay in EMIT, cnt<=REPEAT, no bubble.
  - EMIT, no out_fire: all state holds. outs and outs_valid are stable while outs_valid=1 and outs_ready=0; the block never retracts valid.
- outs is zero whenever outs_valid=0.
- Reset (rst==0 at a clock edge): busy<=0, cnt<=0, outs<=0, hence outs_valid=0 and ctrl_ready=1 after the edge.
  - A burst in progress is discarded without completing.
  - Reset has priority over any handshake in the same cycle.
- ctrl_valid while busy and not on the last-beat fire is backpressured (ctrl_ready=0). The token is held upstream, not dropped.
- No X on any output after the first reset edge.

Optional Feature:
- Macro: HANDSHAKE_CONSTANT_BURST_LAST_EN.
- Defined:
  - Extra port outs_last, output, 1 bit, registered.
  - outs_last = busy & cnt==1, marking the final beat of each burst; reset value 0.
  - Follows the same stability rule as outs.
  - With REPEAT=1, outs_last equals outs_valid.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset and back-to-back, REPEAT=1:
  - Reset, DATA_WIDTH=27, VALUE=0x759B1D8, REPEAT=1 -> outs=0, outs_valid=0, ctrl_ready=1.
  - ctrl_valid=1 and outs_ready=1 for 4 cycles -> 4 output tokens of 0x759B1D8 on consecutive cycles, first token one cycle after the first ctrl_fire.
- Burst of 3 with backpressure:
  - REPEAT=3, one ctrl token, outs_ready low on the 2nd output cycle -> exactly 3 out_fires of VALUE.
  - ctrl_ready=0 until the cycle of the 3rd beat fire; outs stable during the stall.
- Seamless reload:
  - REPEAT=2, ctrl_valid held high, outs_ready=1 -> continuous outs_valid with no bubble.
  - One ctrl_fire every 2 cycles, coinciding with each burst's last beat.
- Reset mid-burst:
  - REPEAT=5, assert rst low after 2 beats -> next cycle outs_valid=0, outs=0, ctrl_ready=1.
  - A new ctrl token yields 5 fresh beats.
- HANDSHAKE_CONSTANT_BURST_LAST_EN defined:
  - REPEAT=4, two bursts -> outs_last high only on beats 4 and 8.
  - With outs_ready stalled on beat 4, outs_last stays high until the fire.
